// File: rtl/h_state_stream_tx.sv
// Snapshots a flat B*H*P*N state tensor on start and streams it out PAR lanes
// per beat over a valid/ready interface, row-major with ragged row tails.
module h_state_stream_tx #(
    parameter int B   = 1,
    parameter int H   = 4,
    parameter int P   = 4,
    parameter int N   = 4,
    parameter int DW  = 16,
    parameter int PAR = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [B*H*P*N*DW-1:0]   h_flat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [PAR*DW-1:0]       m_data,
    output logic [PAR-1:0]          m_keep,
    output logic [9:0]              m_row,
    output logic [9:0]              m_nbase,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done
);

    localparam int ROWS = B * H * P;
    localparam int ROWW = N * DW;
    localparam int TOTW = ROWS * ROWW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TOTW-1:0]   snap_q, snap_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        nbase_q, nbase_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              row_end_s;
    logic              last_beat_s;
    logic [ROWW-1:0]   row_vec_s;
    logic [PAR*DW-1:0] data_s;
    logic [PAR-1:0]    keep_s;

    // Beat position decode: does this beat close its row, and the tensor
    always_comb begin
        row_end_s   = (({1'b0, nbase_q} + 11'(PAR)) >= 11'(N));
        last_beat_s = row_end_s && (row_q == 10'(ROWS - 1));
    end

    // Next-state logic; counters return to zero after the final beat
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        row_d   = row_q;
        nbase_d = nbase_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d  = h_flat;
                    row_d   = 10'd0;
                    nbase_d = 10'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (m_ready) begin
                    if (last_beat_s) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        row_d   = 10'd0;
                        nbase_d = 10'd0;
                    end else if (row_end_s) begin
                        row_d   = row_q + 10'd1;
                        nbase_d = 10'd0;
                    end else begin
                        nbase_d = nbase_q + 10'(PAR);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, snapshot and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            row_q   <= 10'd0;
            nbase_q <= 10'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            nbase_q <= nbase_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Lane mux from registered snapshot and counters; AND-OR form keeps it a pure mux
    always_comb begin
        row_vec_s = '0;
        data_s    = '0;
        keep_s    = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_vec_s = row_vec_s | ({ROWW{row_q == 10'(r)}} & snap_q[r*ROWW +: ROWW]);
        end
        for (int i = 0; i < PAR; i++) begin
            keep_s[i] = valid_q && (({1'b0, nbase_q} + 11'(i)) < 11'(N));
            for (int n = 0; n < N; n++) begin
                data_s[i*DW +: DW] = data_s[i*DW +: DW] |
                    ({DW{valid_q && ((nbase_q + 10'(i)) == 10'(n))}} & row_vec_s[n*DW +: DW]);
            end
        end
    end

    assign m_valid = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign m_data  = data_s;
    assign m_keep  = keep_s;
    assign m_row   = row_q;
    assign m_nbase = nbase_q;
    assign m_last  = valid_q && last_beat_s;

endmodule
